uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter LOCK_TIMEOUT, default 1024, idle cycles before a held packet lock is forcibly released.
REQ-003 Parameter START_TIMEOUT, default 8, cycles allowed for tx_busy to rise after tx_start.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester byte-available flag.
REQ-007 req_data  input  8*N_REQ  requester i byte on bits [8i+7:8i].
REQ-008 req_last  input  N_REQ  byte is the final byte of its packet.
REQ-009 req_ready  output  N_REQ  one-cycle accept pulse per requester.
REQ-010 tx_start  output  1  start pulse to the shared UART transmitter.
REQ-011 tx_data  output  8  byte to the UART transmitter.
REQ-012 tx_busy  input  1  UART transmitter busy.
REQ-013 grant_id  output  clog2(N_REQ)  currently or last granted requester.
REQ-014 locked  output  1  a packet is in progress and owns the UART.
REQ-015 err_start  output  1  sticky: tx_busy failed to rise within START_TIMEOUT.

Function
REQ-016 States: IDLE, START, WAIT_HI, WAIT_LO, HOLD.
REQ-017 IDLE: if any req_valid, winner = first asserted index scanning round-robin from (rr_last+1) mod N_REQ; that cycle req_ready[winner]=1, tx_data<=req_data[winner], grant_id<=winner, locked<=~req_last[winner], next START.
REQ-018 At most one req_ready bit is high in any cycle; req_ready is 0 in START, WAIT_HI and WAIT_LO.
REQ-019 START: tx_start=1 for exactly this one cycle; next WAIT_HI.
REQ-020 Latency: byte accepted in cycle T -> tx_start high in cycle T+1; tx_data stable from T+1 until the next accept.
REQ-021 WAIT_HI: on tx_busy=1 go WAIT_LO; if START_TIMEOUT cycles elapse without tx_busy, set err_start and treat the byte as finished (go to the WAIT_LO exit path).
REQ-022 WAIT_LO: on tx_busy=0, if locked go HOLD, else rr_last<=grant_id and go IDLE.
REQ-023 HOLD: only requester grant_id is served; on its req_valid, req_ready[grant_id]=1, capture byte, locked<=~req_last[grant_id], next START; other requesters' req_valid is ignored.
REQ-024 HOLD timeout: an idle counter increments each HOLD cycle without req_valid[grant_id]; at LOCK_TIMEOUT, clear locked, rr_last<=grant_id, go IDLE; the counter clears on every accept.
REQ-025 A byte accepted in HOLD with req_last=1 releases the lock after its transmission, per REQ-022.
REQ-026 rr_last updates only on packet end (last byte done or lock timeout), so fairness is per packet, not per byte.
REQ-027 tx_busy already high on entry to IDLE or HOLD: no accept until tx_busy=0.
REQ-028 Requester deasserting req_valid without a ready pulse: no effect and no error.

Reset
REQ-029 rst has priority over all other inputs in any state, mid-packet included.
REQ-030 Reset values: state IDLE, req_ready 0, tx_start 0, tx_data 0x00, grant_id 0, locked 0, err_start 0, idle counter 0, rr_last N_REQ-1 (requester 0 has first priority).
REQ-031 The UART transmitter shares rst; no byte in flight at reset is retried.

Verification
REQ-032 Single byte: req_valid[2]=1, data 0x5A, last=1 -> req_ready[2] pulse at T, tx_start at T+1 with tx_data=0x5A, locked=0, back to IDLE after tx_busy falls.
REQ-033 Round-robin: all four valid with last=1 continuously, after reset -> grant order 0,1,2,3,0, one packet each.
REQ-034 Packet lock: req 1 sends 3 bytes (0x11,0x22,0x33, last on 0x33) while req 0 and req 3 are valid -> all three bytes go out back to back before any other grant; then grant 2 or 3 by rotation.
REQ-035 Lock timeout: req 0 sends one byte with last=0, then drops valid -> locked falls exactly LOCK_TIMEOUT cycles after HOLD entry; req 3 is granted next.
REQ-036 Start failure: tx_busy tied 0 -> err_start set START_TIMEOUT cycles after tx_start, stays 1 until rst; arbitration continues.
REQ-037 Reset mid-packet: rst asserted in WAIT_LO with locked=1 -> next cycle all outputs at REQ-030 values; next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle of uart_tx_arbiter.
// The master modport drives requests and tx_busy; the arbiter uses the slave modport.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req_valid;
    logic [8*N_REQ-1:0]       req_data;
    logic [N_REQ-1:0]         req_last;
    logic [N_REQ-1:0]         req_ready;
    logic                     tx_start;
    logic [7:0]               tx_data;
    logic                     tx_busy;
    logic [$clog2(N_REQ)-1:0] grant_id;
    logic                     locked;
    logic                     err_start;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, locked, err_start
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, locked, err_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources: round-robin per packet,
// packet lock with idle timeout, and a sticky flag when tx_busy never answers tx_start.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int START_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW  = $clog2(N_REQ);
    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SCW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   rr_last_r;
    logic [GW-1:0]   grant_id_r;
    logic [LCW-1:0]  idle_cnt_r;
    logic [SCW-1:0]  start_cnt_r;
    logic [7:0]      tx_data_r;
    logic            tx_start_r;
    logic            locked_r;
    logic            err_start_r;

    logic [GW:0]      pick_s;
    logic             accept_s;
    logic [GW-1:0]    sel_s;
    logic [N_REQ-1:0] ready_s;
    logic [7:0]       byte_s;
    logic             last_s;

    // First valid requester after 'last', wrapping; MSB of the result flags a hit.
    function automatic logic [GW:0] rr_pick(input logic [GW-1:0] last,
                                            input logic [N_REQ-1:0] valid);
        logic [GW:0]   res;
        logic [GW-1:0] idx;
        res = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GW'((int'(last) + k) % N_REQ);
            if (!res[GW] && valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Accept decision: IDLE arbitrates, HOLD serves only the lock owner, never while tx_busy.
    always_comb begin
        pick_s   = rr_pick(rr_last_r, bus.req_valid);
        accept_s = 1'b0;
        sel_s    = grant_id_r;
        if (rst || bus.tx_busy) begin
            accept_s = 1'b0;
        end else if (state_r == S_IDLE) begin
            accept_s = pick_s[GW];
            sel_s    = pick_s[GW-1:0];
        end else if (state_r == S_HOLD) begin
            accept_s = bus.req_valid[grant_id_r];
        end else begin
            accept_s = 1'b0;
        end
    end

    // One-hot ready pulse and the selected requester's byte.
    always_comb begin
        ready_s = '0;
        if (accept_s) begin
            ready_s[sel_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
        byte_s = bus.req_data[{sel_s, 3'b000} +: 8];
        last_s = bus.req_last[sel_s];
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            rr_last_r   <= GW'(N_REQ - 1);
            grant_id_r  <= '0;
            idle_cnt_r  <= '0;
            start_cnt_r <= '0;
            tx_data_r   <= 8'h00;
            tx_start_r  <= 1'b0;
            locked_r    <= 1'b0;
            err_start_r <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        tx_data_r  <= byte_s;
                        grant_id_r <= sel_s;
                        locked_r   <= ~last_s;
                        tx_start_r <= 1'b1;
                        state_r    <= S_START;
                    end
                end
                S_START: begin
                    start_cnt_r <= SCW'(1);
                    state_r     <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state_r <= S_WAIT_LO;
                    end else if (start_cnt_r == SCW'(START_TIMEOUT - 1)) begin
                        // Transmitter never answered: flag it and retire the byte.
                        err_start_r <= 1'b1;
                        if (locked_r) begin
                            idle_cnt_r <= '0;
                            state_r    <= S_HOLD;
                        end else begin
                            rr_last_r <= grant_id_r;
                            state_r   <= S_IDLE;
                        end
                    end else begin
                        start_cnt_r <= start_cnt_r + SCW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (locked_r) begin
                            idle_cnt_r <= '0;
                            state_r    <= S_HOLD;
                        end else begin
                            rr_last_r <= grant_id_r;
                            state_r   <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (accept_s) begin
                        tx_data_r  <= byte_s;
                        locked_r   <= ~last_s;
                        tx_start_r <= 1'b1;
                        idle_cnt_r <= '0;
                        state_r    <= S_START;
                    end else if (bus.req_valid[grant_id_r]) begin
                        idle_cnt_r <= idle_cnt_r;
                    end else if (idle_cnt_r == LCW'(LOCK_TIMEOUT - 1)) begin
                        locked_r   <= 1'b0;
                        rr_last_r  <= grant_id_r;
                        idle_cnt_r <= '0;
                        state_r    <= S_IDLE;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + LCW'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.tx_start  = tx_start_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.grant_id  = grant_id_r;
    assign bus.locked    = locked_r;
    assign bus.err_start = err_start_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, then random packet traffic checked
// against a transaction-level model of round-robin, packet lock and tx ordering.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int LT = 40;
    localparam int ST = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT), .START_TIMEOUT(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural UART transmitter
    bit   uart_on = 1'b1;
    int   ust = 0;
    int   ucnt = 0;
    logic saw_start = 1'b0;

    // Random-phase reference model
    logic [8:0] pq [N][$];
    logic       m_free, free_next, m_locked, exp_start, prev_busy;
    int         m_owner, m_rr_last;
    logic [7:0] exp_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[i]        = v;
        bus.req_data[8*i +: 8]  = d;
        bus.req_last[i]         = l;
    endtask

    // Leave the sampling point, advance to just after the next rising edge, run the UART.
    task automatic nxt();
        saw_start = bus.tx_start;
        @(posedge clk);
        #1;
        if (uart_on) begin
            case (ust)
                0: if (saw_start) begin
                    ucnt = $urandom_range(0, 2);
                    if (ucnt == 0) begin
                        bus.tx_busy = 1'b1; ucnt = $urandom_range(0, 3); ust = 2;
                    end else ust = 1;
                end
                1: begin
                    ucnt--;
                    if (ucnt == 0) begin
                        bus.tx_busy = 1'b1; ucnt = $urandom_range(0, 3); ust = 2;
                    end
                end
                2: if (ucnt == 0) begin bus.tx_busy = 1'b0; ust = 0; end else ucnt--;
                default: ust = 0;
            endcase
        end
    endtask

    task automatic drain(input int n);
        repeat (n) begin @(negedge clk); nxt(); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
        nxt(); nxt();
        bus.tx_busy = 1'b0; ust = 0;
        rst = 1'b0;
    endtask

    task automatic model_check();
        logic [N-1:0] rdy, v;
        logic [31:0]  exp_rdy;
        logic [8:0]   hd;
        int w, i;
        rdy = bus.req_ready; v = bus.req_valid;
        if (free_next) begin m_free = 1'b1; free_next = 1'b0; end
        chk("rnd_tx_start", 32'(bus.tx_start), 32'(exp_start));
        if (exp_start) chk("rnd_tx_data", 32'(bus.tx_data), 32'(exp_byte));
        chk("rnd_locked", 32'(bus.locked), 32'(m_locked));
        chk("rnd_grant", 32'(bus.grant_id), 32'(m_owner));
        chk("rnd_err", 32'(bus.err_start), 32'd0);
        w = m_locked ? (v[m_owner] ? m_owner : -1) : rr_pick(m_rr_last, v);
        exp_rdy = (m_free && !bus.tx_busy && w >= 0) ? (32'd1 << w) : 32'd0;
        chk("rnd_ready", 32'(rdy), exp_rdy);
        exp_start = 1'b0;
        i = oh_idx(rdy & v);
        if (i >= 0 && pq[i].size() > 0) begin
            hd = pq[i].pop_front();
            exp_byte = hd[7:0];
            m_locked = ~hd[8];
            m_owner = i;
            exp_start = 1'b1;
            m_free = 1'b0;
        end
        if (prev_busy && !bus.tx_busy) begin
            free_next = 1'b1;
            if (!m_locked) m_rr_last = m_owner;
        end
        prev_busy = bus.tx_busy;
    endtask

    task automatic drive_random();
        logic [8:0] hd;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && $urandom_range(0, 3) != 0) begin
                hd = pq[i][0];
                set_req(i, 1'b1, hd[7:0], hd[8]);
            end else begin
                set_req(i, 1'b0, 8'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        int got [5];
        int acc_id [4];
        logic [7:0] st_dat [3];
        logic st_lk [3];
        logic [7:0] pkt [3];
        int na, ns, k, len;
        logic hit, pb, quiet, done;

        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_busy = 1'b0;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_err", 32'(bus.err_start), 32'd0);
        nxt();

        // Single byte from requester 2
        set_req(2, 1'b1, 8'h5A, 1'b1);
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready), 32'b0100);
        nxt(); bus.req_valid = '0;
        @(negedge clk);
        chk("single_start", 32'(bus.tx_start), 32'd1);
        chk("single_data", 32'(bus.tx_data), 32'h5A);
        chk("single_locked", 32'(bus.locked), 32'd0);
        chk("single_grant", 32'(bus.grant_id), 32'd2);
        chk("single_no_ready", 32'(bus.req_ready), 32'd0);
        nxt();
        @(negedge clk);
        chk("single_start_pulse", 32'(bus.tx_start), 32'd0);
        nxt();
        drain(12);

        // Round-robin, all valid single-byte packets
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'hA0 + i), 1'b1);
        got = '{default: -1};
        na = 0;
        for (int c = 0; c < 200 && na < 5; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin got[na] = oh_idx(bus.req_ready); na++; end
            nxt();
        end
        for (int j = 0; j < 5; j++) chk("rr_order", 32'(got[j]), 32'(j % N));
        bus.req_valid = '0;
        drain(12);

        // Packet lock: requester 1 sends three bytes while 0 and 3 wait
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        set_req(0, 1'b1, 8'hC0, 1'b1);
        set_req(3, 1'b1, 8'hC3, 1'b1);
        set_req(1, 1'b1, pkt[0], 1'b0);
        acc_id = '{default: -1};
        st_dat = '{default: 8'h00};
        st_lk = '{default: 1'b0};
        na = 0; ns = 0; k = 0;
        for (int c = 0; c < 300 && na < 4; c++) begin
            @(negedge clk);
            if (bus.tx_start && ns < 3) begin st_dat[ns] = bus.tx_data; st_lk[ns] = bus.locked; ns++; end
            if (bus.req_ready != '0) begin
                acc_id[na] = oh_idx(bus.req_ready); na++;
                if (bus.req_ready[1]) k++;
            end
            nxt();
            if (k < 3) set_req(1, 1'b1, pkt[k], k == 2);
            else bus.req_valid[1] = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            chk("lock_owner", 32'(acc_id[j]), 32'd1);
            chk("lock_data", 32'(st_dat[j]), 32'(pkt[j]));
            chk("lock_flag", 32'(st_lk[j]), (j == 2) ? 32'd0 : 32'd1);
        end
        chk("lock_next_grant", 32'(acc_id[3]), 32'd3);
        bus.req_valid = '0;
        drain(12);

        // Lock timeout: requester 0 opens a packet then goes quiet
        set_req(0, 1'b1, 8'hA5, 1'b0);
        set_req(3, 1'b1, 8'hB3, 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin chk("lt_first", 32'(bus.req_ready), 32'b0001); hit = 1'b1; end
            nxt();
        end
        chk("lt_accept_seen", 32'(hit), 32'd1);
        bus.req_valid[0] = 1'b0;
        hit = 1'b0; pb = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            if (pb && !bus.tx_busy) hit = 1'b1;
            else begin pb = bus.tx_busy; nxt(); end
        end
        chk("lt_fall_seen", 32'(hit), 32'd1);
        quiet = 1'b1;
        for (int c = 1; c <= LT; c++) begin
            nxt();
            @(negedge clk);
            if (bus.req_ready != '0) quiet = 1'b0;
            if (c == LT) chk("lt_locked_before", 32'(bus.locked), 32'd1);
        end
        chk("lt_quiet", 32'(quiet), 32'd1);
        nxt();
        @(negedge clk);
        chk("lt_locked_after", 32'(bus.locked), 32'd0);
        chk("lt_next_grant", 32'(bus.req_ready), 32'b1000);
        nxt(); bus.req_valid = '0;
        drain(12);

        // Start failure: tx_busy never rises
        uart_on = 1'b0; bus.tx_busy = 1'b0;
        set_req(2, 1'b1, 8'h3C, 1'b1);
        @(negedge clk);
        chk("sf_ready", 32'(bus.req_ready), 32'b0100);
        nxt(); bus.req_valid = '0;
        @(negedge clk);
        chk("sf_start", 32'(bus.tx_start), 32'd1);
        for (int c = 1; c <= ST; c++) begin
            nxt();
            @(negedge clk);
            if (c == ST - 1) chk("sf_err_early", 32'(bus.err_start), 32'd0);
            if (c == ST) chk("sf_err_set", 32'(bus.err_start), 32'd1);
        end
        nxt();
        set_req(1, 1'b1, 8'h1D, 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin chk("sf_continue_id", 32'(bus.req_ready), 32'b0010); hit = 1'b1; end
            nxt();
        end
        chk("sf_continue", 32'(hit), 32'd1);
        bus.req_valid = '0;
        drain(ST + 4);
        @(negedge clk);
        chk("sf_err_sticky", 32'(bus.err_start), 32'd1);
        nxt();

        // Reset while a locked packet waits for tx_busy to fall
        set_req(0, 1'b1, 8'h0F, 1'b1);
        set_req(2, 1'b1, 8'h2E, 1'b0);
        @(negedge clk);
        chk("rm_ready", 32'(bus.req_ready), 32'b0100);
        nxt(); bus.req_valid[2] = 1'b0;
        @(negedge clk);
        nxt(); bus.tx_busy = 1'b1;
        @(negedge clk);
        nxt(); rst = 1'b1;
        @(negedge clk);
        chk("rm_locked_pre", 32'(bus.locked), 32'd1);
        nxt(); bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("rm_ready_rst", 32'(bus.req_ready), 32'd0);
        chk("rm_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rm_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rm_grant", 32'(bus.grant_id), 32'd0);
        chk("rm_locked", 32'(bus.locked), 32'd0);
        chk("rm_err", 32'(bus.err_start), 32'd0);
        uart_on = 1'b1; ust = 0;
        nxt(); rst = 1'b0;
        @(negedge clk);
        chk("rm_next_grant", 32'(bus.req_ready), 32'b0001);
        nxt(); bus.req_valid = '0;
        drain(12);

        // Random packet traffic against the reference model
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 5; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) pq[i].push_back({b == len - 1, 8'($urandom)});
            end
        end
        m_free = 1'b1; free_next = 1'b0; m_locked = 1'b0; exp_start = 1'b0; prev_busy = 1'b0;
        m_owner = 0; m_rr_last = N - 1; exp_byte = 8'h00;
        drive_random();
        done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            model_check();
            done = m_free && !free_next && ust == 0 && !bus.tx_busy &&
                   pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0;
            nxt();
            drive_random();
        end
        chk("rnd_complete", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
